// File: rtl/axi_line_master_if.sv
// rtl/axi_line_master_if.sv - line request/response and AXI4 channel bundle for axi_line_master
interface axi_line_master_if;
  // Line request / completion side (dcache miss/evict logic)
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;

  // AXI4 read address / data
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic [3:0]   rid;
  logic         rlast;

  // AXI4 write address / data / response
  logic         awvalid;
  logic         awready;
  logic [31:0]  awaddr;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready;
  logic [63:0]  wdata;
  logic [7:0]   wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [1:0]   bresp;
  logic [3:0]   bid;

  // View of the line master itself
  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  // View of the environment: requester plus memory-side responder
  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - AXI4 initiator moving one 16-byte cache line per request as a 2-beat burst
module axi_line_master #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input logic               clk,
  input logic               rst_n,
  axi_line_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic         req_ready_q, req_ready_d;
  logic         arvalid_q, arvalid_d;
  logic         rready_q, rready_d;
  logic         awvalid_q, awvalid_d;
  logic         wvalid_q, wvalid_d;
  logic         wlast_q, wlast_d;
  logic [63:0]  wdata_q, wdata_d;
  logic         bready_q, bready_d;
  logic         resp_valid_q, resp_valid_d;
  logic         resp_err_q, resp_err_d;
  logic [127:0] resp_rdata_q, resp_rdata_d;
  logic [31:0]  addr_q, addr_d;
  logic [127:0] line_q, line_d;
  logic [63:0]  rbuf_lo_q, rbuf_lo_d;
  logic         beat_q, beat_d;
  logic         err_q, err_d;

  // Burst shape is fixed: two 8-byte INCR beats with full strobes
  assign bus.arid    = AXI_ID;
  assign bus.awid    = AXI_ID;
  assign bus.arlen   = 8'd1;
  assign bus.awlen   = 8'd1;
  assign bus.arsize  = 3'b011;
  assign bus.awsize  = 3'b011;
  assign bus.arburst = 2'b01;
  assign bus.awburst = 2'b01;
  assign bus.wstrb   = 8'hFF;

  assign bus.req_ready  = req_ready_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.araddr     = addr_q;
  assign bus.rready     = rready_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.awaddr     = addr_q;
  assign bus.wvalid     = wvalid_q;
  assign bus.wdata      = wdata_q;
  assign bus.wlast      = wlast_q;
  assign bus.bready     = bready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  // State and registered outputs; reset leaves only req_ready asserted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      wdata_q      <= '0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      rbuf_lo_q    <= '0;
      beat_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      wdata_q      <= wdata_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      rbuf_lo_q    <= rbuf_lo_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
    end
  end

  // Next state and next output values; errors accumulate without cutting a burst short
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    wlast_d      = wlast_q;
    wdata_d      = wdata_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    addr_d       = addr_q;
    line_d       = line_q;
    rbuf_lo_d    = rbuf_lo_q;
    beat_d       = beat_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d      = bus.req_addr & 32'hFFFF_FFF0;
          line_d      = bus.req_wdata;
          err_d       = 1'b0;
          beat_d      = 1'b0;
          req_ready_d = 1'b0;
          if (bus.req_wr) begin
            awvalid_d = 1'b1;
            state_d   = S_AW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end
        end
      end
      S_AR: begin
        if (arvalid_q && bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (bus.rvalid && rready_q) begin
          // rlast must be low on the first beat and high on the second
          err_d = err_q | (bus.rresp != 2'b00) | (bus.rid != AXI_ID) | (bus.rlast != beat_q);
          if (!beat_q) begin
            rbuf_lo_d = bus.rdata;
            beat_d    = 1'b1;
          end else begin
            rready_d     = 1'b0;
            resp_rdata_d = {bus.rdata, rbuf_lo_q};
            beat_d       = 1'b0;
            state_d      = S_DONE;
          end
        end
      end
      S_AW: begin
        if (awvalid_q && bus.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = line_q[63:0];
          wlast_d   = 1'b0;
          beat_d    = 1'b0;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (wvalid_q && bus.wready) begin
          if (!beat_q) begin
            wdata_d = line_q[127:64];
            wlast_d = 1'b1;
            beat_d  = 1'b1;
          end else begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            beat_d   = 1'b0;
            state_d  = S_B;
          end
        end
      end
      S_B: begin
        if (bus.bvalid && bready_q) begin
          err_d    = err_q | (bus.bresp != 2'b00) | (bus.bid != AXI_ID);
          bready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_line_master.sv
// tb/tb_axi_line_master.sv - self-checking bench for axi_line_master
module tb_axi_line_master;

  localparam logic [3:0] AXI_ID = 4'd1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [127:0] last_line;

  axi_line_master_if bus ();

  axi_line_master #(.AXI_ID(AXI_ID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [1:0]   rresp0;
    logic [1:0]   rresp1;
    logic [1:0]   bresp;
    logic [3:0]   id;
    logic         rlast0;
    logic         rlast1;
    int           stall;
    logic         exp_err;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference rules: any non-OKAY response, foreign ID or misplaced rlast flags the line
  function automatic logic model_err(input logic wr, input logic [1:0] rresp0, input logic [1:0] rresp1,
                                     input logic [1:0] bresp, input logic [3:0] id,
                                     input logic rlast0, input logic rlast1);
    if (wr) return (bresp != 2'b00) || (id != AXI_ID);
    return (rresp0 != 2'b00) || (rresp1 != 2'b00) || (id != AXI_ID) || rlast0 || !rlast1;
  endfunction

  // Drives one full line transaction from a negedge where the master is idle,
  // acting as both requester and memory responder, and checks every visible step.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                         input logic [1:0] rresp0, input logic [1:0] rresp1, input logic [1:0] bresp,
                         input logic [3:0] id, input logic rlast0, input logic rlast1,
                         input int stall, input int gap, input logic hold,
                         input logic exp_err, input logic [127:0] exp_rdata);
    logic [31:0] exp_addr;
    int cnt;
    exp_addr = {addr[31:4], 4'h0};
    cnt = 0;
    chk("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(negedge clk); cnt++;
    if (!hold) bus.req_valid = 1'b0;
    chk("req_ready_busy", bus.req_ready, 1'b0);
    chk("resp_valid_busy", bus.resp_valid, 1'b0);
    if (!wr) begin
      chk("arvalid", bus.arvalid, 1'b1);
      chk("awvalid_quiet", bus.awvalid, 1'b0);
      chk("araddr", bus.araddr, exp_addr);
      chk("ar_const", {bus.arid, bus.arlen, bus.arsize, bus.arburst}, {AXI_ID, 8'd1, 3'd3, 2'b01});
      for (int s = 0; s < stall; s++) begin
        bus.rvalid = 1'b1; bus.rdata = {$urandom, $urandom}; bus.rlast = 1'b1; bus.rresp = 2'b10;
        @(negedge clk); cnt++;
        chk("arvalid_hold", bus.arvalid, 1'b1);
        chk("araddr_stable", bus.araddr, exp_addr);
        chk("rready_in_ar", bus.rready, 1'b0);
      end
      bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rlast = 1'b0;
      bus.arready = 1'b1;
      @(negedge clk); cnt++;
      bus.arready = 1'b0;
      chk("arvalid_drop", bus.arvalid, 1'b0);
      chk("rready_up", bus.rready, 1'b1);
      bus.rvalid = 1'b1; bus.rdata = data[63:0]; bus.rresp = rresp0; bus.rid = id; bus.rlast = rlast0;
      @(negedge clk); cnt++;
      bus.rvalid = 1'b0;
      chk("rready_mid", bus.rready, 1'b1);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); cnt++;
        chk("rready_gap", bus.rready, 1'b1);
        chk("resp_valid_gap", bus.resp_valid, 1'b0);
        chk("req_ready_gap", bus.req_ready, 1'b0);
      end
      bus.rvalid = 1'b1; bus.rdata = data[127:64]; bus.rresp = rresp1; bus.rid = id; bus.rlast = rlast1;
      @(negedge clk); cnt++;
      bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rlast = 1'b0;
      chk("rready_done", bus.rready, 1'b0);
      chk("resp_valid_early", bus.resp_valid, 1'b0);
      @(negedge clk); cnt++;
      // observed half a cycle after the 4th edge following accept on a zero-wait responder
      chk("refill_latency", cnt, 5 + stall + gap);
    end else begin
      chk("awvalid", bus.awvalid, 1'b1);
      chk("arvalid_quiet", bus.arvalid, 1'b0);
      chk("awaddr", bus.awaddr, exp_addr);
      chk("aw_const", {bus.awid, bus.awlen, bus.awsize, bus.awburst}, {AXI_ID, 8'd1, 3'd3, 2'b01});
      for (int s = 0; s < stall; s++) begin
        bus.bvalid = 1'b1; bus.bresp = 2'b10; bus.bid = 4'hF;
        @(negedge clk);
        chk("awvalid_hold", bus.awvalid, 1'b1);
        chk("awaddr_stable", bus.awaddr, exp_addr);
        chk("bready_in_aw", bus.bready, 1'b0);
      end
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      bus.awready = 1'b1;
      @(negedge clk);
      bus.awready = 1'b0;
      chk("awvalid_drop", bus.awvalid, 1'b0);
      chk("w0", {bus.wvalid, bus.wlast, bus.wstrb, bus.wdata}, {1'b1, 1'b0, 8'hFF, data[63:0]});
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("w0_stable", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, 1'b0, data[63:0]});
      end
      bus.wready = 1'b1;
      @(negedge clk);
      bus.wready = 1'b0;
      chk("w1", {bus.wvalid, bus.wlast, bus.wstrb, bus.wdata}, {1'b1, 1'b1, 8'hFF, data[127:64]});
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("w1_stable", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, 1'b1, data[127:64]});
      end
      bus.wready = 1'b1;
      @(negedge clk);
      bus.wready = 1'b0;
      chk("w_end", {bus.wvalid, bus.wlast, bus.bready}, {1'b0, 1'b0, 1'b1});
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("bready_gap", bus.bready, 1'b1);
        chk("resp_valid_gap", bus.resp_valid, 1'b0);
      end
      bus.bvalid = 1'b1; bus.bresp = bresp; bus.bid = id;
      @(negedge clk);
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      chk("bready_drop", bus.bready, 1'b0);
      chk("resp_valid_early", bus.resp_valid, 1'b0);
      @(negedge clk);
    end
    chk("resp_valid", bus.resp_valid, 1'b1);
    chk("resp_err", bus.resp_err, exp_err);
    chk("resp_rdata", bus.resp_rdata, exp_rdata);
    chk("req_ready_back", bus.req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d;
    logic         wr, rl0, rl1, e;
    logic [1:0]   r0, r1, br;
    logic [3:0]   id;

    checks = 0; failures = 0; last_line = '0;
    vecs[0] = '{1'b0, 32'h8000_0018, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                2'b00, 2'b00, 2'b00, 4'd1, 1'b0, 1'b1, 0, 1'b0,
                {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{1'b1, 32'h8000_0020, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                2'b00, 2'b00, 2'b00, 4'd1, 1'b0, 1'b1, 2, 1'b0,
                {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[2] = '{1'b0, 32'h8000_0040, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333},
                2'b00, 2'b10, 2'b00, 4'd1, 1'b0, 1'b1, 1, 1'b1,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333}};
    vecs[3] = '{1'b0, 32'h8000_005C, {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
                2'b00, 2'b00, 2'b00, 4'd1, 1'b0, 1'b1, 0, 1'b0,
                {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}};
    vecs[4] = '{1'b1, 32'h1234_5678, {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002},
                2'b00, 2'b00, 2'b00, 4'd3, 1'b0, 1'b1, 0, 1'b1,
                {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}};
    vecs[5] = '{1'b0, 32'h0000_00F7, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777},
                2'b00, 2'b00, 2'b00, 4'd1, 1'b1, 1'b1, 0, 1'b1,
                {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777}};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
                2'b00, 2'b00, 2'b11, 4'd1, 1'b0, 1'b1, 1, 1'b1,
                {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777}};
    vecs[7] = '{1'b0, 32'h4000_1000, {64'h9999_9999_9999_9999, 64'h0000_0000_0000_0000},
                2'b00, 2'b00, 2'b00, 4'd2, 1'b0, 1'b1, 3, 1'b1,
                {64'h9999_9999_9999_9999, 64'h0000_0000_0000_0000}};

    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rid = '0; bus.rlast = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0; bus.bid = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready,
                       bus.resp_valid, bus.resp_err}, 8'h00);
    chk("rst_addr", {bus.araddr, bus.awaddr, bus.wdata}, 128'h0);
    chk("rst_rdata", bus.resp_rdata, 128'h0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rresp0, vecs[i].rresp1, vecs[i].bresp,
              vecs[i].id, vecs[i].rlast0, vecs[i].rlast1, vecs[i].stall, 0, 1'b0,
              vecs[i].exp_err, vecs[i].exp_rdata);
      last_line = vecs[i].exp_rdata;
    end

    // Slow responder with req_valid held high: one completion, then the held request is taken
    d = {64'hAAAA_0000_BBBB_1111, 64'hCCCC_2222_DDDD_3333};
    run_txn(1'b0, 32'h8000_0100, d, 2'b00, 2'b00, 2'b00, AXI_ID, 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, d);
    last_line = d;
    d = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    run_txn(1'b0, 32'h8000_0110, d, 2'b00, 2'b00, 2'b00, AXI_ID, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, d);
    last_line = d;

    // Reset for one cycle right after the first read beat aborts the refill
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 32'h8000_0200;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 64'h5A5A_5A5A_5A5A_5A5A; bus.rid = AXI_ID; bus.rlast = 1'b0;
    @(negedge clk);
    bus.rvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_outputs", {bus.arvalid, bus.rready, bus.req_ready, bus.resp_valid}, 4'b0010);
    last_line = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", bus.resp_valid, 1'b0);
    end
    d = {64'h1357_9BDF_2468_ACE0, 64'h0ECA_8642_FDB9_7531};
    run_txn(1'b0, 32'h8000_0200, d, 2'b00, 2'b00, 2'b00, AXI_ID, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, d);
    last_line = d;

    // Randomized traffic against the reference rules
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom, $urandom, $urandom};
      r0  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r1  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      id  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : AXI_ID;
      rl0 = ($urandom_range(0, 5) == 0);
      rl1 = ($urandom_range(0, 5) != 0);
      e   = model_err(wr, r0, r1, br, id, rl0, rl1);
      if (!wr) last_line = d;
      run_txn(wr, $urandom, d, r0, r1, br, id, rl0, rl1, $urandom_range(0, 3), $urandom_range(0, 3),
              1'b0, e, last_line);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
